// File: rtl/peg_l2_mac_pause_cntrl_pkg.sv
// Shared constants for the L2 MAC PAUSE controller: parser field indices,
// the MAC control opcode and the pause FSM state encodings.
package peg_l2_mac_pause_cntrl_pkg;

   localparam int MAC_FIDX_DADDR      = 0;
   localparam int MAC_FIDX_SADDR      = 1;
   localparam int MAC_FIDX_ETYPE      = 2;
   localparam int MAC_FIDX_OPCODE     = 3;
   localparam int MAC_FIDX_PAUSE_TIME = 4;

   localparam logic [15:0] PAUSE_CTRL_OPCODE = 16'h0001;

   typedef enum logic [1:0] {
      PAUSE_FSM_IDLE   = 2'd0,
      PAUSE_FSM_REQ    = 2'd1,
      PAUSE_FSM_PAUSED = 2'd2
   } pause_fsm_t;

endpackage

// File: rtl/peg_l2_mac_pause_cntrl_if.sv
// RX parser strobes plus the TX halt handshake seen by the pause controller.
// slave is the controller side, master is the parser/TX side.
interface peg_l2_mac_pause_cntrl_if #(
   parameter int NUM_FIELDS = 8,
   parameter int BFFR_SIZE  = 48
);
   logic [NUM_FIELDS-1:0] rx_field_valid_vec;
   logic [BFFR_SIZE-1:0]  rx_bffr;
   logic                  rx_fcs_chk_valid;
   logic                  rx_fcs_chk_ok;
   logic                  rx_frm_abort;
   logic                  tx_pause_req;
   logic                  tx_pause_ack;
   logic                  tx_pause_active;

   modport slave (
      input  rx_field_valid_vec, rx_bffr, rx_fcs_chk_valid, rx_fcs_chk_ok, rx_frm_abort,
      input  tx_pause_ack,
      output tx_pause_req, tx_pause_active
   );

   modport master (
      output rx_field_valid_vec, rx_bffr, rx_fcs_chk_valid, rx_fcs_chk_ok, rx_frm_abort,
      output tx_pause_ack,
      input  tx_pause_req, tx_pause_active
   );
endinterface

// File: rtl/peg_l2_mac_pause_cntrl_timer.sv
// Pause quanta prescaler and 16-bit remaining-quanta down counter.
// The prescaler is held at zero whenever the timer is not running.
module peg_l2_mac_pause_timer #(
   parameter int QUANTA_CLKS = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_load,
   input  logic [15:0] i_load_val,
   input  logic        i_run,
   output logic        o_quanta_wrap,
   output logic        o_zero,
   output logic [15:0] o_val
);
   localparam int CW = $clog2(QUANTA_CLKS);

   logic [CW-1:0] r_quanta_cntr;
   logic [15:0]   r_val;
   logic          w_wrap;

   assign w_wrap        = i_run && (r_quanta_cntr == CW'(QUANTA_CLKS - 1));
   assign o_quanta_wrap = w_wrap;
   assign o_zero        = (r_val == 16'd0);
   assign o_val         = r_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_quanta_cntr <= '0;
         r_val         <= '0;
      end else if (i_load) begin
         r_quanta_cntr <= '0;
         r_val         <= i_load_val;
      end else if (i_run) begin
         r_quanta_cntr <= w_wrap ? '0 : r_quanta_cntr + CW'(1);
         // Saturate at zero so a stray extra wrap never underflows.
         if (w_wrap && (r_val != 16'd0))
            r_val <= r_val - 16'd1;
      end else begin
         r_quanta_cntr <= '0;
      end
   end
endmodule

// File: rtl/peg_l2_mac_pause_cntrl.sv
// 802.3x PAUSE controller: captures the pause time from the RX parser, commits it
// on a good FCS, then runs the TX halt handshake and counts pause quanta down.
module peg_l2_mac_pause_cntrl
   import peg_l2_mac_pause_cntrl_pkg::*;
#(
   parameter int NUM_FIELDS  = 8,
   parameter int BFFR_SIZE   = 48,
   parameter int QUANTA_CLKS = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           i_config_l2_mac_pause_en,
   peg_l2_mac_pause_cntrl_if.slave        io_pause_if,
   output logic [1:0]                     o_pause_fsm_state,
   output logic [15:0]                    o_pause_timer_val
);
   logic        r_pend_vld;
   logic [15:0] r_pend_time;
   pause_fsm_t  r_state;
   logic        r_tx_pause_req;
   logic        r_tx_pause_active;

   logic        w_en;
   logic        w_commit;
   logic        w_commit_load;
   logic        w_commit_zero;
   logic        w_tmr_run;
   logic        w_tmr_wrap;
   logic        w_tmr_zero;
   logic [15:0] w_tmr_val;
   logic        w_unused;

   assign w_en          = i_config_l2_mac_pause_en;
   assign w_commit      = w_en && io_pause_if.rx_fcs_chk_valid && io_pause_if.rx_fcs_chk_ok && r_pend_vld;
   assign w_commit_load = w_commit && (r_pend_time != 16'd0);
   assign w_commit_zero = w_commit && (r_pend_time == 16'd0);
   assign w_tmr_run     = w_en && (r_state == PAUSE_FSM_PAUSED) && !w_commit;
   assign w_unused      = ^{io_pause_if.rx_bffr[BFFR_SIZE-1:16], io_pause_if.rx_field_valid_vec};

   // An FCS verdict of either polarity, an abort or a new frame start all retire the
   // pending time; a capture only lands when none of those fire in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pend_vld  <= 1'b0;
         r_pend_time <= '0;
      end else if (!w_en) begin
         r_pend_vld  <= 1'b0;
      end else if (io_pause_if.rx_fcs_chk_valid || io_pause_if.rx_frm_abort ||
                   io_pause_if.rx_field_valid_vec[MAC_FIDX_DADDR]) begin
         r_pend_vld  <= 1'b0;
      end else if (io_pause_if.rx_field_valid_vec[MAC_FIDX_PAUSE_TIME]) begin
         r_pend_vld  <= 1'b1;
         r_pend_time <= io_pause_if.rx_bffr[15:0];
      end
   end

   peg_l2_mac_pause_timer #(.QUANTA_CLKS(QUANTA_CLKS)) u_timer (
      .clk           (clk),
      .rst           (rst),
      .i_load        (w_commit_load),
      .i_load_val    (r_pend_time),
      .i_run         (w_tmr_run),
      .o_quanta_wrap (w_tmr_wrap),
      .o_zero        (w_tmr_zero),
      .o_val         (w_tmr_val)
   );

   always_ff @(posedge clk) begin
      if (rst || !w_en) begin
         r_state           <= PAUSE_FSM_IDLE;
         r_tx_pause_req    <= 1'b0;
         r_tx_pause_active <= 1'b0;
      end else begin
         case (r_state)
            PAUSE_FSM_IDLE: begin
               if (w_commit_load) begin
                  r_state        <= PAUSE_FSM_REQ;
                  r_tx_pause_req <= 1'b1;
               end
            end
            PAUSE_FSM_REQ: begin
               if (w_commit_zero) begin
                  r_state        <= PAUSE_FSM_IDLE;
                  r_tx_pause_req <= 1'b0;
               end else if (!w_commit_load && io_pause_if.tx_pause_ack) begin
                  r_state           <= PAUSE_FSM_PAUSED;
                  r_tx_pause_active <= 1'b1;
               end
            end
            PAUSE_FSM_PAUSED: begin
               // A reload beats a same-cycle final wrap; ack level is ignored here.
               if (!w_commit_load &&
                   (w_commit_zero || (w_tmr_wrap && w_tmr_val == 16'd1) || w_tmr_zero)) begin
                  r_state           <= PAUSE_FSM_IDLE;
                  r_tx_pause_req    <= 1'b0;
                  r_tx_pause_active <= 1'b0;
               end
            end
            default: begin
               r_state           <= PAUSE_FSM_IDLE;
               r_tx_pause_req    <= 1'b0;
               r_tx_pause_active <= 1'b0;
            end
         endcase
      end
   end

   assign io_pause_if.tx_pause_req    = r_tx_pause_req;
   assign io_pause_if.tx_pause_active = r_tx_pause_active;
   assign o_pause_fsm_state           = r_state;
   assign o_pause_timer_val           = (r_state == PAUSE_FSM_IDLE) ? 16'd0 : w_tmr_val;
endmodule
